// File: rtl/cam_pwr_seq_pkg.sv
// Shared types and default tick counts for the camera power sequencer.
// One tick is a single cycle of the 400kHz strobe (2.5us).
package cam_pwr_seq_pkg;

  localparam int SEQ_CNT_W = 20;

  typedef logic [SEQ_CNT_W-1:0] seq_cnt_t;

  typedef enum logic [2:0] {
    S_WAIT_RDY = 3'd0,
    S_PWR      = 3'd1,
    S_CAM_ON   = 3'd2,
    S_INIT     = 3'd3,
    S_RUN      = 3'd4,
    S_OFF      = 3'd5,
    S_FAULT    = 3'd6
  } cam_seq_state_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_IDLY_TO  = 2'd1,
    FLT_INIT_TO  = 2'd2,
    FLT_RDY_LOST = 2'd3
  } cam_fault_t;

  localparam int NUM_TICK_IDLY_TO = 4000;
  localparam int NUM_TICK_PWR     = 800000;
  localparam int NUM_TICK_I2C     = 800000;
  localparam int NUM_TICK_INIT_TO = 400000;
  localparam int NUM_TICK_OFF     = 40000;

  function automatic bit tick_limit_ok(int t);
    return (t >= 1) && (t <= 2**SEQ_CNT_W);
  endfunction

  // Counter value on which the T-th tick since state entry lands.
  function automatic seq_cnt_t tick_last(int t);
    return seq_cnt_t'(t - 1);
  endfunction

  function automatic logic cam_en_of(cam_seq_state_t s);
    return (s == S_CAM_ON) || (s == S_INIT) || (s == S_RUN);
  endfunction

  function automatic logic i2c_reset_of(cam_seq_state_t s);
    return !((s == S_INIT) || (s == S_RUN));
  endfunction

endpackage

// File: rtl/cam_pwr_seq.sv
// Camera bring-up sequencer: gates on IDELAYCTRL ready, times power and I2C
// release off the 400kHz strobe, and handles timeouts, ready loss and restart.
module cam_pwr_seq
  import cam_pwr_seq_pkg::*;
#(
  parameter int T_IDLY_TO = NUM_TICK_IDLY_TO,
  parameter int T_PWR     = NUM_TICK_PWR,
  parameter int T_I2C     = NUM_TICK_I2C,
  parameter int T_INIT_TO = NUM_TICK_INIT_TO,
  parameter int T_OFF     = NUM_TICK_OFF
) (
  input  logic       clk_100,
  input  logic       reset,
  input  logic       strobe_400kHz,
  input  logic       idelay_rdy,
  input  logic       i2c_init_done,
  input  logic       restart_req,
  output logic       cam_en,
  output logic       i2c_reset,
  output logic       seq_ready,
  output logic       seq_fault,
  output logic [1:0] fault_code,
  output logic [2:0] state_dbg
);

  if (!tick_limit_ok(T_IDLY_TO)) begin : g_chk_idly_to
    $error("cam_pwr_seq: T_IDLY_TO must be in 1..2^20");
  end
  if (!tick_limit_ok(T_PWR)) begin : g_chk_pwr
    $error("cam_pwr_seq: T_PWR must be in 1..2^20");
  end
  if (!tick_limit_ok(T_I2C)) begin : g_chk_i2c
    $error("cam_pwr_seq: T_I2C must be in 1..2^20");
  end
  if (!tick_limit_ok(T_INIT_TO)) begin : g_chk_init_to
    $error("cam_pwr_seq: T_INIT_TO must be in 1..2^20");
  end
  if (!tick_limit_ok(T_OFF)) begin : g_chk_off
    $error("cam_pwr_seq: T_OFF must be in 1..2^20");
  end

  localparam seq_cnt_t IDLY_TO_LAST = tick_last(T_IDLY_TO);
  localparam seq_cnt_t PWR_LAST     = tick_last(T_PWR);
  localparam seq_cnt_t I2C_LAST     = tick_last(T_I2C);
  localparam seq_cnt_t INIT_TO_LAST = tick_last(T_INIT_TO);
  localparam seq_cnt_t OFF_LAST     = tick_last(T_OFF);

  cam_seq_state_t state_q;
  cam_seq_state_t state_nxt;
  cam_fault_t     fault_q;
  cam_fault_t     fault_nxt;
  seq_cnt_t       seq_cnt;

  logic idly_to_done;
  logic pwr_done;
  logic i2c_done;
  logic init_to_done;
  logic off_done;

  // The single timer is shared, so each "elapsed" flag is only meaningful in its own state.
  assign idly_to_done = strobe_400kHz && (seq_cnt == IDLY_TO_LAST);
  assign pwr_done     = strobe_400kHz && (seq_cnt == PWR_LAST);
  assign i2c_done     = strobe_400kHz && (seq_cnt == I2C_LAST);
  assign init_to_done = strobe_400kHz && (seq_cnt == INIT_TO_LAST);
  assign off_done     = strobe_400kHz && (seq_cnt == OFF_LAST);

  always_comb begin
    state_nxt = state_q;
    fault_nxt = fault_q;
    if (restart_req && (state_q != S_OFF)) begin
      state_nxt = S_OFF;
      fault_nxt = FLT_NONE;
    end else begin
      case (state_q)
        S_WAIT_RDY: begin
          if (idelay_rdy) begin
            state_nxt = S_PWR;
          end else if (idly_to_done) begin
            state_nxt = S_FAULT;
            fault_nxt = FLT_IDLY_TO;
          end
        end
        S_PWR: begin
          if (!idelay_rdy) begin
            state_nxt = S_FAULT;
            fault_nxt = FLT_RDY_LOST;
          end else if (pwr_done) begin
            state_nxt = S_CAM_ON;
          end
        end
        S_CAM_ON: begin
          if (!idelay_rdy) begin
            state_nxt = S_FAULT;
            fault_nxt = FLT_RDY_LOST;
          end else if (i2c_done) begin
            state_nxt = S_INIT;
          end
        end
        S_INIT: begin
          if (!idelay_rdy) begin
            state_nxt = S_FAULT;
            fault_nxt = FLT_RDY_LOST;
          end else if (i2c_init_done) begin
            state_nxt = S_RUN;
          end else if (init_to_done) begin
            state_nxt = S_FAULT;
            fault_nxt = FLT_INIT_TO;
          end
        end
        S_RUN: begin
          if (!idelay_rdy) begin
            state_nxt = S_FAULT;
            fault_nxt = FLT_RDY_LOST;
          end
        end
        S_OFF: begin
          if (off_done) begin
            state_nxt = S_WAIT_RDY;
          end
        end
        S_FAULT: begin
          state_nxt = S_FAULT;
        end
        default: begin
          state_nxt = S_FAULT;
          fault_nxt = FLT_NONE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state_q.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT_RDY;
      fault_q   <= FLT_NONE;
      seq_cnt   <= '0;
      cam_en    <= 1'b0;
      i2c_reset <= 1'b1;
      seq_ready <= 1'b0;
      seq_fault <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      fault_q   <= fault_nxt;
      cam_en    <= cam_en_of(state_nxt);
      i2c_reset <= i2c_reset_of(state_nxt);
      seq_ready <= (state_nxt == S_RUN);
      seq_fault <= (state_nxt == S_FAULT);
      if (state_nxt != state_q) begin
        seq_cnt <= '0;
      end else if (strobe_400kHz) begin
        seq_cnt <= seq_cnt + 1'b1;
      end
    end
  end

  assign fault_code = fault_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Bench for cam_pwr_seq: directed bring-up/fault scenarios plus a randomized
// run, all checked against a tick-counting phase model of the sequencer.
module tb_cam_pwr_seq;

  logic       clk_100 = 1'b0;
  logic       reset = 1'b1;
  logic       strobe_400kHz = 1'b0;
  logic       idelay_rdy = 1'b0;
  logic       i2c_init_done = 1'b0;
  logic       restart_req = 1'b0;
  logic       cam_en;
  logic       i2c_reset;
  logic       seq_ready;
  logic       seq_fault;
  logic [1:0] fault_code;
  logic [2:0] state_dbg;
  logic [8:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int clk_cnt = 0;

  // Reference model: phase number (as seen on state_dbg), ticks seen in phase, fault code.
  int m_st = 0;
  int m_tk = 0;
  int m_code = 0;
  int lim [7] = '{8, 4, 3, 10, 0, 5, 0};
  int st_ticks [8];

  cam_pwr_seq #(
    .T_IDLY_TO(8),
    .T_PWR    (4),
    .T_I2C    (3),
    .T_INIT_TO(10),
    .T_OFF    (5)
  ) dut (
    .clk_100      (clk_100),
    .reset        (reset),
    .strobe_400kHz(strobe_400kHz),
    .idelay_rdy   (idelay_rdy),
    .i2c_init_done(i2c_init_done),
    .restart_req  (restart_req),
    .cam_en       (cam_en),
    .i2c_reset    (i2c_reset),
    .seq_ready    (seq_ready),
    .seq_fault    (seq_fault),
    .fault_code   (fault_code),
    .state_dbg    (state_dbg)
  );

  always #5 clk_100 = ~clk_100;

  assign dut_vec = {cam_en, i2c_reset, seq_ready, seq_fault, fault_code, state_dbg};

  function automatic logic [8:0] exp_vec();
    logic [1:0] c;
    logic [2:0] s;
    c = 2'(m_code);
    s = 3'(m_st);
    return {logic'(m_st inside {2, 3, 4}), logic'(!(m_st inside {3, 4})),
            logic'(m_st == 4), logic'(m_st == 6), c, s};
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_tk = 0;
    m_code = 0;
    for (int i = 0; i < 8; i++) st_ticks[i] = 0;
  endtask

  task automatic model_update();
    int nxt;
    int nc;
    bit fin;
    nxt = m_st;
    nc = m_code;
    fin = strobe_400kHz && (lim[m_st] != 0) && (m_tk + 1 == lim[m_st]);
    if (restart_req && m_st != 5) begin
      nxt = 5;
      nc = 0;
    end else if (m_st == 0) begin
      if (idelay_rdy) nxt = 1;
      else if (fin) begin nxt = 6; nc = 1; end
    end else if ((m_st inside {1, 2, 3, 4}) && !idelay_rdy) begin
      nxt = 6;
      nc = 3;
    end else if (m_st == 3) begin
      if (i2c_init_done) nxt = 4;
      else if (fin) begin nxt = 6; nc = 2; end
    end else if (fin) begin
      nxt = (m_st == 1) ? 2 : (m_st == 2) ? 3 : 0;
    end
    if (nxt != m_st) m_tk = 0;
    else if (strobe_400kHz) m_tk++;
    m_st = nxt;
    m_code = nc;
  endtask

  // One clock: strobe on every 4th cycle, model follows the edge, sample 1ns later.
  task automatic step();
    strobe_400kHz = (clk_cnt % 4 == 3);
    if (strobe_400kHz && !reset) st_ticks[state_dbg]++;
    clk_cnt++;
    @(posedge clk_100);
    if (!reset) model_update();
    #1;
    restart_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    step();
    step();
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    n_cmp++; if (cam_en !== 1'b0) begin n_bad++; $display("FAIL reset_cam_en got=%b exp=0", cam_en); end
    n_cmp++; if (i2c_reset !== 1'b1) begin n_bad++; $display("FAIL reset_i2c_reset got=%b exp=1", i2c_reset); end
    n_cmp++; if (seq_ready !== 1'b0) begin n_bad++; $display("FAIL reset_seq_ready got=%b exp=0", seq_ready); end
    n_cmp++; if (seq_fault !== 1'b0) begin n_bad++; $display("FAIL reset_seq_fault got=%b exp=0", seq_fault); end
    n_cmp++; if (fault_code !== 2'd0) begin n_bad++; $display("FAIL reset_fault_code got=%0d exp=0", fault_code); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_nominal();
    int seq_q[$];
    int exp_seq [5] = '{0, 1, 2, 3, 4};
    int last;
    bit set_now;
    do_reset();
    idelay_rdy = 1'b0;
    i2c_init_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL nominal_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
    end
    idelay_rdy = 1'b1;
    seq_q.push_back(int'(state_dbg));
    last = int'(state_dbg);
    for (int cyc = 0; cyc < 400 && state_dbg != 3'd4; cyc++) begin
      set_now = 1'b0;
      if (state_dbg == 3'd3 && st_ticks[3] >= 2 && !i2c_init_done) begin
        i2c_init_done = 1'b1;
        set_now = 1'b1;
      end
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL nominal_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
      if (set_now) begin
        n_cmp++; if (seq_ready !== 1'b1) begin n_bad++; $display("FAIL nominal_ready_latency got=%b exp=1", seq_ready); end
      end
      if (int'(state_dbg) != last) begin
        last = int'(state_dbg);
        seq_q.push_back(last);
      end
    end
    n_cmp++; if (state_dbg !== 3'd4) begin n_bad++; $display("FAIL nominal_reach_run got=%0d exp=4", state_dbg); end
    n_cmp++; if (st_ticks[1] != 4) begin n_bad++; $display("FAIL nominal_pwr_ticks got=%0d exp=4", st_ticks[1]); end
    n_cmp++; if (st_ticks[2] != 3) begin n_bad++; $display("FAIL nominal_i2c_ticks got=%0d exp=3", st_ticks[2]); end
    n_cmp++; if (seq_q.size() != 5) begin n_bad++; $display("FAIL nominal_seq_len got=%0d exp=5", seq_q.size()); end
    for (int i = 0; i < 5 && i < seq_q.size(); i++) begin
      n_cmp++; if (seq_q[i] != exp_seq[i]) begin n_bad++; $display("FAIL nominal_seq[%0d] got=%0d exp=%0d", i, seq_q[i], exp_seq[i]); end
    end
    i2c_init_done = 1'b0;
  endtask

  task automatic test_idly_timeout();
    do_reset();
    idelay_rdy = 1'b0;
    for (int cyc = 0; cyc < 100 && seq_fault !== 1'b1; cyc++) begin
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL idly_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
    end
    n_cmp++; if (seq_fault !== 1'b1) begin n_bad++; $display("FAIL idly_fault got=%b exp=1", seq_fault); end
    n_cmp++; if (fault_code !== 2'd1) begin n_bad++; $display("FAIL idly_code got=%0d exp=1", fault_code); end
    n_cmp++; if ({cam_en, i2c_reset} !== 2'b01) begin n_bad++; $display("FAIL idly_outputs got=%b exp=01", {cam_en, i2c_reset}); end
    n_cmp++; if (st_ticks[0] != 8) begin n_bad++; $display("FAIL idly_ticks got=%0d exp=8", st_ticks[0]); end
    step();
    restart_req = 1'b1;
    step();
    n_cmp++; if ({state_dbg, seq_fault, fault_code} !== {3'd5, 1'b0, 2'd0}) begin n_bad++; $display("FAIL idly_restart got=%b exp=101000", {state_dbg, seq_fault, fault_code}); end
    for (int cyc = 0; cyc < 100 && state_dbg != 3'd0; cyc++) begin
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL idly_off_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
    end
    n_cmp++; if (state_dbg !== 3'd0 || st_ticks[5] != 5) begin n_bad++; $display("FAIL idly_off_ticks got=%0d state=%0d exp=5 state=0", st_ticks[5], state_dbg); end
  endtask

  task automatic test_init_timeout();
    do_reset();
    idelay_rdy = 1'b1;
    i2c_init_done = 1'b0;
    for (int cyc = 0; cyc < 200 && seq_fault !== 1'b1; cyc++) begin
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL init_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
    end
    n_cmp++; if (fault_code !== 2'd2) begin n_bad++; $display("FAIL init_code got=%0d exp=2", fault_code); end
    n_cmp++; if (cam_en !== 1'b0) begin n_bad++; $display("FAIL init_cam_en got=%b exp=0", cam_en); end
    n_cmp++; if (st_ticks[3] != 10) begin n_bad++; $display("FAIL init_ticks got=%0d exp=10", st_ticks[3]); end
  endtask

  task automatic test_rdy_loss();
    do_reset();
    idelay_rdy = 1'b1;
    i2c_init_done = 1'b1;
    for (int cyc = 0; cyc < 200 && state_dbg != 3'd4; cyc++) step();
    n_cmp++; if (seq_ready !== 1'b1) begin n_bad++; $display("FAIL loss_reach_run got=%b exp=1", seq_ready); end
    step();
    idelay_rdy = 1'b0;
    step();
    idelay_rdy = 1'b1;
    n_cmp++; if ({seq_fault, fault_code, seq_ready, cam_en} !== 5'b11100) begin n_bad++; $display("FAIL loss_outputs got=%b exp=11100", {seq_fault, fault_code, seq_ready, cam_en}); end
    step();
    n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL loss_hold got=%b exp=%b", dut_vec, exp_vec()); end
    i2c_init_done = 1'b0;
  endtask

  task automatic test_restart_tie();
    do_reset();
    idelay_rdy = 1'b1;
    i2c_init_done = 1'b0;
    for (int cyc = 0; cyc < 200 && !(state_dbg == 3'd2 && st_ticks[2] == 2 && clk_cnt % 4 == 3); cyc++) begin
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL tie_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
    end
    restart_req = 1'b1;
    step();
    n_cmp++; if ({state_dbg, cam_en} !== {3'd5, 1'b0}) begin n_bad++; $display("FAIL tie_off got=%b exp=1010", {state_dbg, cam_en}); end
    for (int cyc = 0; cyc < 50 && st_ticks[5] < 2; cyc++) step();
    restart_req = 1'b1;
    for (int cyc = 0; cyc < 100 && state_dbg != 3'd0; cyc++) begin
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL tie_off_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
    end
    n_cmp++; if (state_dbg !== 3'd0 || st_ticks[5] != 5) begin n_bad++; $display("FAIL tie_off_ticks got=%0d state=%0d exp=5 state=0", st_ticks[5], state_dbg); end
  endtask

  task automatic test_reset_mid_init();
    do_reset();
    idelay_rdy = 1'b1;
    i2c_init_done = 1'b0;
    for (int cyc = 0; cyc < 200 && state_dbg != 3'd3; cyc++) step();
    step();
    step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++; if ({i2c_reset, cam_en, state_dbg} !== {1'b1, 1'b0, 3'd0}) begin n_bad++; $display("FAIL async_reset got=%b exp=10000", {i2c_reset, cam_en, state_dbg}); end
    step();
    reset = 1'b0;
    model_reset();
    i2c_init_done = 1'b1;
    for (int cyc = 0; cyc < 200 && state_dbg != 3'd4; cyc++) begin
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL rst_restart_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
    end
    n_cmp++; if (state_dbg !== 3'd4 || st_ticks[1] != 4) begin n_bad++; $display("FAIL rst_restart_run state=%0d pwr_ticks=%0d exp state=4 pwr_ticks=4", state_dbg, st_ticks[1]); end
    i2c_init_done = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    idelay_rdy = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(63) == 0) idelay_rdy = ~idelay_rdy;
      i2c_init_done = ($urandom_range(5) == 0);
      restart_req = ($urandom_range(39) == 0);
      step();
      n_cmp++; if (dut_vec !== exp_vec()) begin n_bad++; $display("FAIL random_model t=%0t got=%b exp=%b", $time, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_idly_timeout();
    test_init_timeout();
    test_rdy_loss();
    test_restart_tie();
    test_reset_mid_init();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
